// File: rtl/alu.sv
// Two-operand integer ALU with registered result, carry, zero and overflow flags.
// One shared adder serves ADD, SUB and the signed SLT comparison.
module alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             in_c,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpNot = 3'b010,
    OpAnd = 3'b011,
    OpOr  = 3'b100,
    OpXor = 3'b101,
    OpSlt = 3'b110,
    OpEq  = 3'b111
  } op_e;

  localparam int unsigned Msb = WIDTH - 1;

  op_e              op_sel;
  logic             use_sub;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic             add_v;
  logic             less;

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;
  logic             z_d, z_q;
  logic             v_d, v_q;

  assign op_sel = op_e'(op);

  // SUB and SLT both compute x + ~y + 1 on the shared adder.
  always_comb begin
    use_sub = (op_sel == OpSub) || (op_sel == OpSlt);
    add_b   = use_sub ? ~in_y : in_y;
    if (use_sub) begin
      add_cin = 1'b1;
    end else if (op_sel == OpAdd) begin
      add_cin = in_c;
    end else begin
      add_cin = 1'b0;
    end
    add_sum = {1'b0, in_x} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_s   = add_sum[WIDTH-1:0];
    add_c   = add_sum[WIDTH];
    // With add_b already inverted for SUB, one overflow rule covers both cases.
    add_v   = (in_x[Msb] == add_b[Msb]) && (add_s[Msb] != in_x[Msb]);
    less    = add_s[Msb] ^ add_v;
  end

  always_comb begin
    s_d = '0;
    c_d = 1'b0;
    v_d = 1'b0;
    unique case (op_sel)
      OpAdd, OpSub: begin
        s_d = add_s;
        c_d = add_c;
        v_d = add_v;
      end
      OpNot: s_d = ~in_x;
      OpAnd: s_d = in_x & in_y;
      OpOr:  s_d = in_x | in_y;
      OpXor: s_d = in_x ^ in_y;
      OpSlt: s_d = {{(WIDTH-1){1'b0}}, less};
      OpEq:  s_d = {{(WIDTH-1){1'b0}}, (in_x == in_y)};
      default: s_d = '0;
    endcase
    z_d = (s_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b1;
      v_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      z_q <= z_d;
      v_q <= v_d;
    end
  end

  assign out_s    = s_q;
  assign out_c    = c_q;
  assign zero     = z_q;
  assign overflow = v_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, random vectors against an
// integer reference model, and hand-written reset/latency sequences.
module tb_alu;

  localparam int unsigned W = 4;
  localparam int unsigned RW = W + 3;

  logic         clk;
  logic         rst_n;
  logic [2:0]   op;
  logic         in_c;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic [W-1:0] out_s;
  logic         out_c;
  logic         zero;
  logic         overflow;

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .in_c     (in_c),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_s    (out_s),
    .out_c    (out_c),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic         cin;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [RW-1:0] exp; // {s, c, zero, overflow}
  } vec_t;

  typedef struct {
    logic [RW-1:0] exp;
    int            id;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_checks;
  int   n_pass;

  function automatic logic [RW-1:0] pack(input logic [W-1:0] s, input logic c, input logic z,
                                         input logic v);
    return {s, c, z, v};
  endfunction

  // Reference computed with plain integer arithmetic, not adder bit tricks.
  function automatic logic [RW-1:0] model(input logic [2:0] o, input logic ci,
                                          input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy, sx, sy, u, sv, smax, smin;
    logic [W-1:0] s;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (o)
      3'b000: begin
        u  = ux + uy + int'(ci);
        s  = W'(u);
        c  = (u >= (1 << W));
        sv = sx + sy + int'(ci);
        v  = (sv > smax) || (sv < smin);
      end
      3'b001: begin
        s  = W'(ux - uy + (1 << W));
        c  = (ux >= uy);
        sv = sx - sy;
        v  = (sv > smax) || (sv < smin);
      end
      3'b010: s = ~x;
      3'b011: s = x & y;
      3'b100: s = x | y;
      3'b101: s = x ^ y;
      3'b110: s = (sx < sy) ? W'(1) : W'(0);
      default: s = (ux == uy) ? W'(1) : W'(0);
    endcase
    return pack(s, c, (s == '0), v);
  endfunction

  function automatic logic [RW-1:0] dut_out();
    return {out_s, out_c, zero, overflow};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got s=%h c=%b z=%b v=%b, expected s=%h c=%b z=%b v=%b", name,
               act[RW-1:3], act[2], act[1], act[0], exp[RW-1:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive on the falling edge, push expectation, pop and compare just after the capture edge.
  task automatic run_vec(input vec_t v, input int id);
    sb_t e;
    @(negedge clk);
    op   = v.op;
    in_c = v.cin;
    in_x = v.x;
    in_y = v.y;
    sb.push_back('{exp: v.exp, id: id});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check($sformatf("scoreboard_empty_%0d", id), dut_out(), ~dut_out());
    end else begin
      e = sb.pop_front();
      check($sformatf("vec_%0d_op%0d", e.id, v.op), dut_out(), e.exp);
    end
  endtask

  initial begin
    vec_t rv;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    op    = 3'b000;
    in_c  = 1'b0;
    in_x  = '0;
    in_y  = '0;

    //            op      cin   x      y      {s, c, z, v}
    tbl.push_back('{3'b000, 1'b0, 4'h1, 4'h1, pack(4'h2, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b000, 1'b0, 4'hF, 4'h1, pack(4'h0, 1'b1, 1'b1, 1'b0)});
    tbl.push_back('{3'b000, 1'b1, 4'h7, 4'h0, pack(4'h8, 1'b0, 1'b0, 1'b1)});
    tbl.push_back('{3'b001, 1'b1, 4'h3, 4'h3, pack(4'h0, 1'b1, 1'b1, 1'b0)});
    tbl.push_back('{3'b001, 1'b0, 4'h8, 4'h1, pack(4'h7, 1'b1, 1'b0, 1'b1)});
    tbl.push_back('{3'b001, 1'b1, 4'h1, 4'h2, pack(4'hF, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b011, 1'b1, 4'hA, 4'h6, pack(4'h2, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b100, 1'b1, 4'hA, 4'h6, pack(4'hE, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b101, 1'b1, 4'hA, 4'h6, pack(4'hC, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b010, 1'b1, 4'hA, 4'hF, pack(4'h5, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b011, 1'b0, 4'hA, 4'h5, pack(4'h0, 1'b0, 1'b1, 1'b0)});
    tbl.push_back('{3'b110, 1'b0, 4'hF, 4'h1, pack(4'h1, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b110, 1'b0, 4'h1, 4'hF, pack(4'h0, 1'b0, 1'b1, 1'b0)});
    tbl.push_back('{3'b110, 1'b0, 4'h8, 4'h7, pack(4'h1, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b111, 1'b1, 4'h5, 4'h5, pack(4'h1, 1'b0, 1'b0, 1'b0)});
    tbl.push_back('{3'b111, 1'b0, 4'h5, 4'h4, pack(4'h0, 1'b0, 1'b1, 1'b0)});

    // Reset state while clocks run.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out(), pack(4'h0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], i);

    for (int i = 0; i < 40; i++) begin
      rv.op  = 3'($urandom_range(0, 7));
      rv.cin = 1'($urandom_range(0, 1));
      rv.x   = W'($urandom_range(0, (1 << W) - 1));
      rv.y   = W'($urandom_range(0, (1 << W) - 1));
      rv.exp = model(rv.op, rv.cin, rv.x, rv.y);
      run_vec(rv, 100 + i);
    end

    // Asynchronous reset mid-cycle after a nonzero result.
    run_vec('{3'b000, 1'b0, 4'h1, 4'h1, pack(4'h2, 1'b0, 1'b0, 1'b0)}, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", dut_out(), pack(4'h0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    op   = 3'b000;
    in_c = 1'b0;
    in_x = 4'h2;
    in_y = 4'h3;
    @(posedge clk);
    #1;
    check("reset_held_over_edge", dut_out(), pack(4'h0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge_yet", dut_out(), pack(4'h0, 1'b0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    check("first_capture_after_release", dut_out(), pack(4'h5, 1'b0, 1'b0, 1'b0));

    // Operands changed between edges must not disturb the registered outputs.
    @(negedge clk);
    in_x = 4'h7;
    #1;
    check("mid_cycle_change_ignored", dut_out(), pack(4'h5, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("mid_cycle_change_captured", dut_out(), pack(4'hA, 1'b0, 1'b0, 1'b1));

    if (sb.size() != 0) begin
      check("scoreboard_drained", W'(sb.size()), '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Parameterised two-operand integer ALU producing a result plus carry, zero and overflow flags. It is the arithmetic/logic datapath element of the processor execute stage and is fed directly from operand registers. All outputs are registered, so results appear one clock after the operands and opcode are presented.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- op  input  3  operation select
- in_c  input  1  carry-in, used by ADD only
- in_x  input  WIDTH  operand X
- in_y  input  WIDTH  operand Y
- out_s  output  WIDTH  registered result
- out_c  output  1  registered carry-out
- zero  output  1  registered flag, 1 when the result is all zeros
- overflow  output  1  registered two's-complement overflow flag

## Operation
- op 000 ADD: {c,s} = x + y + in_c; overflow = (x[MSB]==y[MSB]) && (s[MSB]!=x[MSB]).
- op 001 SUB: s = x + ~y + 1, so in_c is ignored; c = adder carry-out, which is 1 when x ≥ y unsigned (no borrow); overflow = (x[MSB]!=y[MSB]) && (s[MSB]!=x[MSB]).
- op 010 NOT: s = ~x.
- op 011 AND: s = x & y.
- op 100 OR: s = x | y.
- op 101 XOR: s = x ^ y.
- op 110 SLT: s = {0…,1} if x < y signed, else 0.
- op 111 EQ: s = {0…,1} if x == y, else 0.
- For ops 010–111, out_c = 0 and overflow = 0.
- zero = (s == 0) for every op, including the logic ops and SLT/EQ.
- All arithmetic is modulo 2^WIDTH. The carry and overflow are taken from the WIDTH-bit adder.
- A single shared adder serves ADD, SUB and the SLT comparison. For SLT, less = s[MSB] ^ overflow of the SUB computation.

## Timing
- Combinational result and flags are computed from op, in_c, in_x and in_y, then captured into the output registers on every rising clk.
- Latency is 1 cycle: inputs stable before edge N give outputs valid after edge N.
- The block has no handshake and no enable. It captures every cycle, and back-to-back operations give one new result per cycle.
- Inputs changing between edges have no effect on the outputs until the next edge.
- rst_n low (asynchronous, at any time, including mid-operation) forces:
  - out_s = 0
  - out_c = 0
  - overflow = 0
  - zero = 1
- These values are held while rst_n is low.
- The first capture occurs on the first rising clk edge after rst_n deasserts.

## Test plan
- ADD: x=1, y=1, in_c=0 → after 1 edge, out_s=2, out_c=0, overflow=0, zero=0.
- ADD wrap and carry-in: x=F, y=1, in_c=0 → out_s=0, out_c=1, zero=1, overflow=0. x=7, y=0, in_c=1 → out_s=8, overflow=1, out_c=0.
- SUB: x=3, y=3 → out_s=0, out_c=1, zero=1, overflow=0. x=8, y=1 → out_s=7, out_c=1, overflow=1. x=1, y=2 → out_s=F, out_c=0.
- Logic ops:
  - x=A, y=6: AND → 2, OR → E, XOR → C.
  - x=A: NOT → 5.
  - All of the above give out_c=0 and overflow=0.
  - x=A, y=5, AND → 0, zero=1.
- Compare ops:
  - SLT x=F, y=1 → out_s=1 (−1 < 1).
  - SLT x=1, y=F → out_s=0, zero=1.
  - SLT x=8, y=7 → out_s=1.
  - EQ x=5, y=5 → 1.
  - EQ x=5, y=4 → 0.
- Reset and latency:
  - Assert rst_n low between edges after a nonzero result → outputs immediately go to 0/0/0 and zero=1.
  - Apply ADD 2+3 with rst_n low → no change.
  - Release rst_n → out_s=5 only after the next rising edge.
  - Changing operands mid-cycle does not alter the outputs.
